// File: rtl/ahb_apb_bridge_ctrl.sv
// AHB-slave to APB-master bridge controller: each accepted AHB transfer is replayed
// as one two-phase APB access while the AHB data phase is stalled via Hreadyout.
module ahb_apb_bridge_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter logic [31:0] REGION_SIZE = 32'h0400_0000,
    parameter int          NUM_PSEL    = 4
) (
    input  logic                clk,
    input  logic                Hreset,
    input  logic                Hwrite,
    input  logic                Hreadyin,
    input  logic [1:0]          Htrans,
    input  logic [31:0]         Haddr,
    input  logic [31:0]         Hwdata,
    output logic                Hreadyout,
    output logic [1:0]          Hresp,
    output logic [31:0]         Hrdata,
    output logic [NUM_PSEL-1:0] Pselx,
    output logic                Penable,
    output logic                Pwrite,
    output logic [31:0]         Paddr,
    output logic [31:0]         Pwdata,
    input  logic [31:0]         Prdata,
    input  logic                Pready
);

    localparam int          REGION_LOG2 = $clog2(REGION_SIZE);
    localparam int          IDX_W       = (NUM_PSEL > 1) ? $clog2(NUM_PSEL) : 1;
    localparam logic [32:0] WINDOW      = 33'(NUM_PSEL) * {1'b0, REGION_SIZE};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ENABLE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                hreadyout_q, hreadyout_d;
    logic [31:0]         hrdata_q, hrdata_d;
    logic [NUM_PSEL-1:0] pselx_q, pselx_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [31:0]         paddr_q, paddr_d;
    logic [31:0]         pwdata_q, pwdata_d;
    logic [IDX_W-1:0]    sel_q, sel_d;

    logic [31:0]      offset;
    logic             in_window;
    logic             valid;
    logic [IDX_W-1:0] haddr_idx;

    // Haddr >= BASE_ADDR guarantees the subtraction does not wrap.
    assign offset    = Haddr - BASE_ADDR;
    assign in_window = (Haddr >= BASE_ADDR) && ({1'b0, offset} < WINDOW);
    assign valid     = Hreadyin && (Htrans inside {2'b10, 2'b11}) && in_window;
    assign haddr_idx = IDX_W'(offset >> REGION_LOG2);

    always_comb begin
        state_d   = state_q;
        hrdata_d  = hrdata_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        sel_d     = sel_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (valid) begin
                    paddr_d  = Haddr;
                    pwrite_d = Hwrite;
                    sel_d    = haddr_idx;
                    state_d  = Hwrite ? ST_WDATA : ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WDATA: begin
                pwdata_d = Hwdata;
                state_d  = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (Pready) begin
                    state_d = ST_DONE;
                    if (!pwrite_q) begin
                        hrdata_d = Prdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        penable_d   = (state_d == ST_ENABLE);
        pselx_d     = '0;
        if ((state_d == ST_SETUP) || (state_d == ST_ENABLE)) begin
            pselx_d[sel_d] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge Hreset) begin
        if (Hreset) begin
            state_q     <= ST_IDLE;
            hreadyout_q <= 1'b1;
            hrdata_q    <= '0;
            pselx_q     <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            sel_q       <= '0;
        end else begin
            state_q     <= state_d;
            hreadyout_q <= hreadyout_d;
            hrdata_q    <= hrdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            sel_q       <= sel_d;
        end
    end

    assign Hreadyout = hreadyout_q;
    assign Hresp     = 2'b00;
    assign Hrdata    = hrdata_q;
    assign Pselx     = pselx_q;
    assign Penable   = penable_q;
    assign Pwrite    = pwrite_q;
    assign Paddr     = paddr_q;
    assign Pwdata    = pwdata_q;

endmodule

// File: tb/tb_ahb_apb_bridge_ctrl.sv
// Bench for ahb_apb_bridge_ctrl: directed and random AHB transfers, with the expected
// APB phase schedule and read data derived per transfer from the bridge's stated timing.
module tb_ahb_apb_bridge_ctrl;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] REGION = 32'h0400_0000;
    localparam int          NPSEL  = 4;

    logic        clk = 1'b0;
    logic        Hreset;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [3:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_hrdata;

    ahb_apb_bridge_ctrl #(
        .BASE_ADDR  (BASE),
        .REGION_SIZE(REGION),
        .NUM_PSEL   (NPSEL)
    ) dut (
        .clk      (clk),
        .Hreset   (Hreset),
        .Hwrite   (Hwrite),
        .Hreadyin (Hreadyin),
        .Htrans   (Htrans),
        .Haddr    (Haddr),
        .Hwdata   (Hwdata),
        .Hreadyout(Hreadyout),
        .Hresp    (Hresp),
        .Hrdata   (Hrdata),
        .Pselx    (Pselx),
        .Penable  (Penable),
        .Pwrite   (Pwrite),
        .Paddr    (Paddr),
        .Pwdata   (Pwdata),
        .Prdata   (Prdata),
        .Pready   (Pready)
    );

    always #5 clk = ~clk;

    function automatic bit in_win(input logic [31:0] a);
        longint la;
        la = longint'(a);
        return (la >= longint'(BASE)) &&
               (la < longint'(BASE) + longint'(NPSEL) * longint'(REGION));
    endfunction

    function automatic logic [3:0] exp_sel(input logic [31:0] a);
        int idx;
        idx = int'((longint'(a) - longint'(BASE)) / longint'(REGION));
        return 4'(1 << idx);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; leaves the bridge in its ready cycle so the
    // next call can issue a back-to-back address phase.
    task automatic xfer(input bit wr, input logic [1:0] trans, input bit rdyin,
                        input logic [31:0] addr, input logic [31:0] wdata, input int waits);
        logic [31:0] rdata;
        logic [3:0]  sel;
        bit          hit;
        int          first_en;
        int          last;
        bit          en;
        bit          wph;
        hit      = rdyin && trans[1] && in_win(addr);
        sel      = hit ? exp_sel(addr) : 4'b0000;
        rdata    = $urandom;
        Hwrite   = wr;
        Htrans   = trans;
        Haddr    = addr;
        Hreadyin = rdyin;
        Prdata   = rdata;
        Pready   = 1'b0;
        @(posedge clk); #1;
        Htrans   = 2'b00;
        Hreadyin = 1'b1;
        Haddr    = $urandom;
        Hwrite   = 1'($urandom);
        Hwdata   = wdata;
        if (!hit) begin
            check("ign_hreadyout", 32'(Hreadyout), 32'd1);
            check("ign_pselx", 32'(Pselx), 32'd0);
            check("ign_penable", 32'(Penable), 32'd0);
            check("ign_hrdata", Hrdata, exp_hrdata);
            $display("xfer ignored wr=%0d trans=%b rdy=%0d addr=%h", wr, trans, rdyin, addr);
            return;
        end
        first_en = wr ? 2 : 1;
        last     = first_en + waits;
        for (int c = 0; c <= last; c++) begin
            en     = (c >= first_en);
            wph    = wr && (c == 0);
            Pready = en && (c == last);
            check("busy_hreadyout", 32'(Hreadyout), 32'd0);
            check("busy_penable", 32'(Penable), 32'(en));
            check("busy_pselx", 32'(Pselx), wph ? 32'd0 : 32'(sel));
            if (!wph) begin
                check("busy_paddr", Paddr, addr);
                check("busy_pwrite", 32'(Pwrite), 32'(wr));
                if (wr) check("busy_pwdata", Pwdata, wdata);
            end
            @(posedge clk); #1;
        end
        Pready = 1'b0;
        if (!wr) exp_hrdata = rdata;
        check("done_hreadyout", 32'(Hreadyout), 32'd1);
        check("done_hresp", 32'(Hresp), 32'd0);
        check("done_pselx", 32'(Pselx), 32'd0);
        check("done_penable", 32'(Penable), 32'd0);
        check("done_hrdata", Hrdata, exp_hrdata);
        $display("xfer %s addr=%h sel=%b waits=%0d wdata=%h hrdata=%h",
                 wr ? "WR" : "RD", addr, sel, waits, wdata, Hrdata);
    endtask

    initial begin
        logic [31:0] edges [4];
        logic [31:0] a;
        int          r;
        logic [1:0]  tr;
        edges[0] = 32'h7FFF_FFFC;
        edges[1] = 32'h8FFF_FFFC;
        edges[2] = 32'h9000_0000;
        edges[3] = 32'h8000_0000;

        Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00;
        Haddr = '0; Hwdata = '0; Prdata = '0; Pready = 1'b0;
        exp_hrdata = '0;
        @(posedge clk); #1;
        check("rst_hreadyout", 32'(Hreadyout), 32'd1);
        check("rst_pselx", 32'(Pselx), 32'd0);
        check("rst_penable", 32'(Penable), 32'd0);
        check("rst_pwrite", 32'(Pwrite), 32'd0);
        check("rst_paddr", Paddr, 32'd0);
        check("rst_pwdata", Pwdata, 32'd0);
        check("rst_hrdata", Hrdata, 32'd0);
        check("rst_hresp", 32'(Hresp), 32'd0);
        Hreset = 1'b0;
        @(posedge clk); #1;

        // directed: write, read, wait states, ignored transfers
        xfer(1'b1, 2'b10, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 0);
        xfer(1'b0, 2'b10, 1'b1, 32'h8400_0004, 32'h0, 0);
        xfer(1'b0, 2'b10, 1'b1, 32'h8800_0000, 32'h0, 3);
        xfer(1'b0, 2'b01, 1'b1, 32'h8000_0000, 32'h0, 0);
        xfer(1'b0, 2'b10, 1'b1, 32'h9000_0000, 32'h0, 0);

        // back-to-back INCR burst: DONE must go straight to the next WDATA
        for (int i = 0; i < 4; i++) begin
            xfer(1'b1, (i == 0) ? 2'b10 : 2'b11, 1'b1, 32'h8C00_0000 + 32'(4 * i),
                 $urandom, 0);
        end

        // reset asserted mid-ENABLE aborts the access
        Hwrite = 1'b0; Htrans = 2'b10; Haddr = 32'h8800_0000; Pready = 1'b0;
        @(posedge clk); #1;
        Htrans = 2'b00;
        @(posedge clk); #1;
        check("pre_rst_penable", 32'(Penable), 32'd1);
        #2 Hreset = 1'b1;
        #1;
        check("arst_pselx", 32'(Pselx), 32'd0);
        check("arst_penable", 32'(Penable), 32'd0);
        check("arst_hreadyout", 32'(Hreadyout), 32'd1);
        check("arst_hrdata", Hrdata, 32'd0);
        exp_hrdata = '0;
        @(posedge clk); #1;
        Hreset = 1'b0;
        @(posedge clk); #1;
        check("post_rst_hreadyout", 32'(Hreadyout), 32'd1);
        $display("xfer RD aborted by reset");

        // random transfers, including window edges and Hreadyin=0
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 9);
            tr = (r < 1) ? 2'b00 : (r < 2) ? 2'b01 : (r < 6) ? 2'b10 : 2'b11;
            r  = $urandom_range(0, 9);
            if (r < 8)       a = (BASE + $urandom_range(0, 32'h0FFF_FFFF)) & ~32'h3;
            else if (r == 8) a = edges[$urandom_range(0, 3)];
            else             a = $urandom;
            xfer(1'($urandom), tr, ($urandom_range(0, 9) != 0), a, $urandom,
                 $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
